// File: rtl/tlm_frame_serializer.sv
// Telemetry minor-frame builder and MSB-first serializer: SYNC1, SYNC2, data field with embedded subframe counter.
// Optional CCSDS pseudo-randomizer on the data field when TLM_FRAME_RANDOMIZER_EN is defined.
`timescale 1ns/1ps
module tlm_frame_serializer #(
  parameter int unsigned       WORD_W    = 16,
  parameter int unsigned       NUM_WORDS = 10,
  parameter int unsigned       SF_POS    = 4,
  parameter int unsigned       SF_MAX    = 9,
  parameter logic [WORD_W-1:0] SYNC1     = 16'hFE6B,
  parameter logic [WORD_W-1:0] SYNC2     = 16'h2840,
  parameter logic [WORD_W-1:0] FILL_WORD = 16'hAAAA
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              bit_out,
  output logic              word_strobe,
  output logic              frame_start,
  output logic              sync_active,
  output logic              underflow,
  output logic [15:0]       sf_count
);

  localparam int unsigned     NUM_SLOTS = NUM_WORDS + 2;
  localparam int unsigned     WI_W      = $clog2(NUM_SLOTS);
  localparam int unsigned     BI_W      = $clog2(WORD_W);
  localparam logic [WI_W-1:0] LAST_IDX  = WI_W'(NUM_SLOTS - 1);
  localparam logic [WI_W-1:0] SF_IDX    = WI_W'(SF_POS + 2);
  localparam logic [WI_W-1:0] SYNC2_IDX = WI_W'(1);
  localparam logic [WI_W-1:0] DATA0_IDX = WI_W'(2);
  localparam logic [BI_W-1:0] MSB_BIT   = BI_W'(WORD_W - 1);
  localparam logic [15:0]     SF_TOP    = 16'(SF_MAX);

  if (SF_POS >= NUM_WORDS || SF_MAX >= 65536) begin : g_bad_frame_cfg
    $error("tlm_frame_serializer: SF_POS must be < NUM_WORDS and SF_MAX must be < 2^16");
  end
  if (WORD_W < 4 || WORD_W > 32 || NUM_WORDS < 2 || NUM_WORDS > 1023) begin : g_bad_size_cfg
    $error("tlm_frame_serializer: WORD_W must be 4..32 and NUM_WORDS 2..1023");
  end

  // Position of the bit currently on bit_out; r_run is low only between reset and the first frame.
  logic [WI_W-1:0]   r_word_idx;
  logic [BI_W-1:0]   r_bit_idx;
  logic              r_run;
  logic [WORD_W-1:0] r_shift;
  logic              r_bit_out;
  logic              r_word_strobe;
  logic              r_frame_start;
  logic              r_sync_active;
  logic [15:0]       r_sf_count;

  logic              w_word_end;
  logic              w_frame_end;
  logic [WI_W-1:0]   w_next_idx;
  logic              w_next_is_data;
  logic [WORD_W-1:0] w_next_word;
  logic [WI_W-1:0]   w_pos_idx;
  logic              w_raw_bit;
  logic              w_data_field;
  logic              w_rand_bit;

  // After reset r_bit_idx is 0, so the first active cycle takes the word-load path into SYNC1.
  assign w_word_end     = (r_bit_idx == '0);
  assign w_frame_end    = r_run && w_word_end && (r_word_idx == LAST_IDX);
  assign w_next_is_data = (w_next_idx >= DATA0_IDX) && (w_next_idx != SF_IDX);

  always_comb begin
    w_next_idx = '0;
    if (r_run && (r_word_idx != LAST_IDX)) begin
      w_next_idx = r_word_idx + WI_W'(1);
    end
  end

  // The SF slot reads r_sf_count, which was already advanced at the end of the previous frame.
  always_comb begin
    w_next_word = FILL_WORD;
    if (w_next_idx == '0) begin
      w_next_word = SYNC1;
    end else if (w_next_idx == SYNC2_IDX) begin
      w_next_word = SYNC2;
    end else if (w_next_idx == SF_IDX) begin
      w_next_word = WORD_W'(r_sf_count);
    end else if (data_valid) begin
      w_next_word = data_in;
    end
  end

  assign w_pos_idx    = w_word_end ? w_next_idx : r_word_idx;
  assign w_raw_bit    = w_word_end ? w_next_word[WORD_W-1] : r_shift[WORD_W-1];
  assign w_data_field = (w_pos_idx >= DATA0_IDX);

  // NOTE: a word is consumed only when the load edge really happens, so a reset in the ready cycle drops the handshake.
  assign data_ready = r_run && w_word_end && w_next_is_data && !reset;
  assign underflow  = data_ready && !data_valid;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_run         <= 1'b0;
      r_word_idx    <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_bit_out     <= 1'b0;
      r_word_strobe <= 1'b0;
      r_frame_start <= 1'b0;
      r_sync_active <= 1'b0;
      r_sf_count    <= '0;
    end else begin
      r_run      <= 1'b1;
      r_word_idx <= w_pos_idx;
      // r_shift holds the not-yet-sent bits of the current word, next bit at the MSB.
      if (w_word_end) begin
        r_bit_idx <= MSB_BIT;
        r_shift   <= {w_next_word[WORD_W-2:0], 1'b0};
      end else begin
        r_bit_idx <= r_bit_idx - BI_W'(1);
        r_shift   <= {r_shift[WORD_W-2:0], 1'b0};
      end
      if (w_frame_end) begin
        r_sf_count <= (r_sf_count == SF_TOP) ? 16'd0 : r_sf_count + 16'd1;
      end
      r_word_strobe <= w_word_end;
      r_frame_start <= w_word_end && (w_next_idx == '0);
      r_sync_active <= !w_data_field;
      r_bit_out     <= w_raw_bit ^ w_rand_bit;
    end
  end

`ifdef TLM_FRAME_RANDOMIZER_EN
  // Fibonacci form of h(x)=x^8+x^7+x^5+x^3+1: r_lfsr[7] is the oldest sequence bit and the one applied.
  logic [7:0] r_lfsr;

  assign w_rand_bit = w_data_field && r_lfsr[7];

  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_lfsr <= '1;
    end else if (w_word_end && (w_next_idx == '0)) begin
      r_lfsr <= '1;
    end else if (w_data_field) begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[4] ^ r_lfsr[2] ^ r_lfsr[0]};
    end
  end
`else
  assign w_rand_bit = 1'b0;
`endif

  assign bit_out     = r_bit_out;
  assign word_strobe = r_word_strobe;
  assign frame_start = r_frame_start;
  assign sync_active = r_sync_active;
  assign sf_count    = r_sf_count;

endmodule
